// File: rtl/wave_pkg.sv
// Shared types and default widths for the wave capture sequencer.
package wave_pkg;

  localparam int DEF_ADDR_WIDTH = 10;
  localparam int DEF_DATA_WIDTH = 8;

  localparam logic SLOPE_RISE = 1'b0;
  localparam logic SLOPE_FALL = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    PRE,
    WAIT_TRIG,
    POST,
    DONE
  } wave_state_t;

endpackage

// File: rtl/wave_trig_det.sv
// Level/slope trigger detector: remembers the previous written sample and compares it with the current one.
// Latency: trig_hit is combinational on the current sample; the history register updates on each valid sample.
// Backpressure: none; it follows the writer's sample_valid and is re-armed by clear.
module wave_trig_det
  import wave_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear,
  input  logic                  sample_valid,
  input  logic [DATA_WIDTH-1:0] sample_data,
  input  logic [DATA_WIDTH-1:0] trig_level,
  input  logic                  trig_slope,
  output logic                  trig_hit
);

  logic [DATA_WIDTH-1:0] prev;
  logic                  prev_ok;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev    <= '0;
      prev_ok <= 1'b0;
    end else if (clear) begin
      prev_ok <= 1'b0;
    end else if (sample_valid) begin
      prev    <= sample_data;
      prev_ok <= 1'b1;
    end
  end

  // Unsigned compares: samples are offset-binary.
  always_comb begin
    trig_hit = 1'b0;
    if (sample_valid && prev_ok) begin
      if (trig_slope == SLOPE_RISE)
        trig_hit = (prev < trig_level) && (sample_data >= trig_level);
      else
        trig_hit = (prev > trig_level) && (sample_data <= trig_level);
    end
  end

endmodule

// File: rtl/wave_capture_ctrl.sv
// Circular-buffer capture sequencer for the wave RAM with pre-trigger history and indexed readout; WAVE_AUTO_TRIG_EN adds a forced-trigger timeout.
// Latency: RAM writes are combinational on sample_valid; readout data returns 2 cycles after rd_req.
// Backpressure: none; every valid sample while busy is written, one read request accepted per cycle in DONE.
module wave_capture_ctrl
  import wave_pkg::*;
#(
  parameter int ADDR_WIDTH        = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH        = DEF_DATA_WIDTH,
  parameter int PRE_TRIG          = 256,
  parameter int AUTO_TRIG_SAMPLES = 4096
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  arm,
  input  logic [DATA_WIDTH-1:0] trig_level,
  input  logic                  trig_slope,
  input  logic                  sample_valid,
  input  logic [DATA_WIDTH-1:0] sample_data,
  output logic                  ram_wr_en,
  output logic [ADDR_WIDTH-1:0] ram_wr_addr,
  output logic [DATA_WIDTH-1:0] ram_wr_data,
  output logic [ADDR_WIDTH-1:0] ram_rd_addr,
  input  logic [DATA_WIDTH-1:0] ram_rd_data,
  input  logic                  rd_req,
  input  logic [ADDR_WIDTH-1:0] rd_index,
  output logic                  rd_valid,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] trig_addr,
  output logic                  auto_trig
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] PRE_LAST = ADDR_WIDTH'(PRE_TRIG - 1);
  localparam logic [ADDR_WIDTH-1:0] PRE_OFS  = ADDR_WIDTH'(PRE_TRIG);
  localparam logic [ADDR_WIDTH-1:0] POST_LEN = ADDR_WIDTH'(DEPTH - PRE_TRIG - 1);
  localparam logic [ADDR_WIDTH-1:0] ONE      = ADDR_WIDTH'(1);

  wave_state_t           state, state_nxt;
  logic [ADDR_WIDTH-1:0] wptr;
  logic [ADDR_WIDTH-1:0] cnt;
  logic                  arm_ok;
  logic                  wr_fire;
  logic                  trig_hit;
  logic                  auto_hit;
  logic                  trig_fire;
  logic                  rd_ok;
  logic                  rd_p1;

  assign busy      = (state == PRE) || (state == WAIT_TRIG) || (state == POST);
  assign done      = (state == DONE);
  assign arm_ok    = arm && ((state == IDLE) || (state == DONE));
  assign wr_fire   = busy && sample_valid;
  assign trig_fire = (state == WAIT_TRIG) && sample_valid && (trig_hit || auto_hit);
  // A same-cycle arm in DONE takes priority and drops the request.
  assign rd_ok     = done && rd_req && !arm;

  assign ram_wr_en   = wr_fire;
  assign ram_wr_addr = wptr;
  assign ram_wr_data = wr_fire ? sample_data : '0;
  assign rd_data     = rd_valid ? ram_rd_data : '0;

  wave_trig_det #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_trig_det (
    .clk          (clk),
    .rst_n        (rst_n),
    .clear        (arm_ok),
    .sample_valid (wr_fire),
    .sample_data  (sample_data),
    .trig_level   (trig_level),
    .trig_slope   (trig_slope),
    .trig_hit     (trig_hit)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE, DONE: begin
        if (arm) state_nxt = (PRE_TRIG == 0) ? WAIT_TRIG : PRE;
      end
      PRE: begin
        if (sample_valid && (cnt == PRE_LAST)) state_nxt = WAIT_TRIG;
      end
      WAIT_TRIG: begin
        if (trig_fire) state_nxt = (POST_LEN == '0) ? DONE : POST;
      end
      POST: begin
        if (sample_valid && (cnt == ONE)) state_nxt = DONE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // cnt is the pre-trigger fill count in PRE and the remaining post count in POST.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr      <= '0;
      cnt       <= '0;
      trig_addr <= '0;
    end else if (arm_ok) begin
      cnt <= '0;
    end else if (wr_fire) begin
      wptr <= wptr + ONE;
      unique case (state)
        PRE:       cnt <= (cnt == PRE_LAST) ? '0 : cnt + ONE;
        WAIT_TRIG: begin
          if (trig_fire) begin
            cnt       <= POST_LEN;
            trig_addr <= wptr;
          end
        end
        POST:      cnt <= cnt - ONE;
        default:   cnt <= cnt;
      endcase
    end
  end

  // Two-stage read return: address register, then the RAM's own 1-cycle read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ram_rd_addr <= '0;
      rd_p1       <= 1'b0;
      rd_valid    <= 1'b0;
    end else begin
      if (rd_ok) ram_rd_addr <= trig_addr - PRE_OFS + rd_index;
      rd_p1    <= rd_ok;
      rd_valid <= rd_p1;
    end
  end

`ifdef WAVE_AUTO_TRIG_EN
  localparam int TO_W = $clog2(AUTO_TRIG_SAMPLES + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(AUTO_TRIG_SAMPLES - 1);

  logic [TO_W-1:0] to_cnt;
  logic            auto_q;

  assign auto_hit  = (state == WAIT_TRIG) && (to_cnt == TO_LAST);
  assign auto_trig = auto_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      to_cnt <= '0;
      auto_q <= 1'b0;
    end else if (arm_ok) begin
      to_cnt <= '0;
      auto_q <= 1'b0;
    end else if ((state == WAIT_TRIG) && sample_valid) begin
      to_cnt <= to_cnt + TO_W'(1);
      // A genuine crossing on the timeout sample still counts as a real trigger.
      if (auto_hit && !trig_hit) auto_q <= 1'b1;
    end
  end
`else
  assign auto_hit  = 1'b0;
  assign auto_trig = 1'b0;
`endif

endmodule
